stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 153 +++++++++++++++
 tb/tb_stream_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO with valid/ready
//             handshakes on both sides. Storage is a plain register array
//             addressed by wrap-bit pointers. Full/empty come from comparing
//             the pointers.
//  Revision : 1.0 - initial release
//
//  Optional : `define STREAM_FIFO_STATUS_EN adds the count / almost_full
//             status ports and the logic behind them.
//
//  Ports
//    clk          in   1      single clock, rising edge
//    rst_n        in   1      asynchronous active-low reset
//    flush        in   1      synchronous clear of all stored entries
//    in_valid     in   1      write-side valid
//    in_ready     out  1      write-side ready (not full, out of reset)
//    in_data      in   WIDTH  write data
//    out_valid    out  1      read-side valid (not empty)
//    out_ready    in   1      read-side ready
//    out_data     out  WIDTH  head entry, zero when out_valid=0
//    count        out  A+1    occupancy 0..DEPTH    (STREAM_FIFO_STATUS_EN)
//    almost_full  out  1      count >= AFULL_THRESH (STREAM_FIFO_STATUS_EN)
// ============================================================================
module stream_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
`ifdef STREAM_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // Reject configurations outside the supported range at elaboration.
  localparam bit c_CFG_OK = (WIDTH >= 1) && (DEPTH >= 2) &&
                            ((1 << ADDR_W) == DEPTH) &&
                            (AFULL_THRESH >= 1) && (AFULL_THRESH <= DEPTH);

  if (!c_CFG_OK) begin : g_bad_cfg
    $error("stream_fifo: unsupported WIDTH/DEPTH/AFULL_THRESH combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_en;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  // Same index with opposite lap bit means the writer is a full lap ahead.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

  // in_ready depends only on registered state, so a read in the same cycle
  // cannot open a slot for a write while full.
  assign in_ready  = r_en & ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? r_mem[r_rptr[ADDR_W-1:0]] : '0;

  // flush takes priority over any handshake completing in the same cycle.
  assign w_wr = in_valid  & in_ready  & ~flush;
  assign w_rd = out_valid & out_ready & ~flush;

  // r_en holds in_ready low through reset and releases it on the first edge
  // after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  // Pointers advance by one and carry naturally into the lap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Storage is not reset. Stale contents never reach out_data because the
  // output is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= in_data;
    end
  end

`ifdef STREAM_FIFO_STATUS_EN
  logic [PTR_W-1:0] r_count;
  logic [PTR_W-1:0] w_count_nxt;
  logic             r_afull;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_wr && !w_rd) begin
      w_count_nxt = r_count + PTR_W'(1);
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - PTR_W'(1);
    end
  end

  // almost_full is computed from the next count so that it changes on the
  // same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= PTR_W'(AFULL_THRESH));
    end
  end

  assign count       = r_count;
  assign almost_full = r_afull;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fifo
//  Purpose  : Self-checking bench for stream_fifo (WIDTH=8, DEPTH=4,
//             AFULL_THRESH=2). A vector table covers fill, the full-stall
//             case, drain, flush and empty reads. Hand-written sequences
//             cover reset release, continuous streaming and mid-stream reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NVEC  = 20;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             almost_full;

  int n_tests;
  int n_fail;

  stream_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef STREAM_FIFO_STATUS_EN
    ,
    .count        (count),
    .almost_full  (almost_full)
`endif
  );

`ifndef STREAM_FIFO_STATUS_EN
  assign count       = '0;
  assign almost_full = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle, plus outputs expected in that cycle
  // before the clock edge.
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
    logic       e_af;
  } vec_t;

  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input logic [2:0] e_cnt, input logic e_af);
`ifdef STREAM_FIFO_STATUS_EN
    chk({name, " cnt/af"}, {28'd0, count, almost_full}, {28'd0, e_cnt, e_af});
`else
    if (e_cnt > 3'd4 || e_af === 1'bx) begin
      $display("note: bad status vector in %s", name);
    end
`endif
  endtask

  // Called at posedge+1: drive, settle, check pre-edge outputs, clock.
  task automatic step(input int idx);
    in_valid  = vec[idx].iv;
    in_data   = vec[idx].id;
    out_ready = vec[idx].ordy;
    flush     = vec[idx].fl;
    #1;
    chk($sformatf("vec%0d ir/ov/od", idx),
        {22'd0, in_ready, out_valid, out_data},
        {22'd0, vec[idx].e_ir, vec[idx].e_ov, vec[idx].e_od});
    chk_status($sformatf("vec%0d", idx), vec[idx].e_cnt, vec[idx].e_af);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //                iv  id     ordy fl   ir  ov  od     cnt   af
    vec[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0};
    vec[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1};
    vec[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1};
    // Full: read accepted, write refused in the same cycle.
    vec[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1};
    vec[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd4, 1'b1};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 3'd2, 1'b1};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0};
    // Empty: out_ready ignored.
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vec[11] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0};
    vec[13] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0};
    vec[14] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 3'd2, 1'b1};
    // Flush with 3 held plus a concurrent write and read.
    vec[15] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 3'd3, 1'b1};
    vec[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vec[17] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vec[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 3'd1, 1'b0};
    vec[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state and release.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset ir/ov/od", {22'd0, in_ready, out_valid, out_data}, 32'd0);
    chk_status("reset", 3'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    #1;
    chk("release in_ready before edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release in_ready after edge", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      step(i);
    end

    // Continuous streaming, 256 words across many pointer wraps.
    for (int k = 0; k < 257; k++) begin
      in_valid  = (k < 256);
      in_data   = 8'(k);
      out_ready = 1'b1;
      flush     = 1'b0;
      #1;
      if (k == 0) begin
        chk("stream k0 out_valid", {31'd0, out_valid}, 32'd0);
        chk_status("stream k0", 3'd0, 1'b0);
      end else begin
        chk($sformatf("stream k%0d ov/od", k), {23'd0, out_valid, out_data},
            {23'd0, 1'b1, 8'(k - 1)});
        chk_status($sformatf("stream k%0d", k), 3'd1, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stream drained", {31'd0, out_valid}, 32'd0);
    chk_status("stream drained", 3'd0, 1'b0);

    // Mid-stream reset with 2 entries held.
    in_valid = 1'b1;
    in_data  = 8'h12;
    @(posedge clk);
    #1;
    in_data = 8'h34;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre-reset ov/od", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h12});
    chk_status("pre-reset", 3'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ir/ov/od", {22'd0, in_ready, out_valid, out_data}, 32'd0);
    chk_status("async reset", 3'd0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post-release in_ready before edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post-release ir/ov/od", {22'd0, in_ready, out_valid, out_data},
        {22'd0, 1'b1, 1'b0, 8'h00});
    chk_status("post-release", 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
